// File: rtl/imem_if.sv
// Instruction-memory request/ready port: the fetch stage drives req/addr and the
// memory answers with ready/rdata.
interface imem_if;
  logic        req;
  logic [15:0] addr;
  logic        ready;
  logic [15:0] rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, drives a variable-latency imem port and holds
// the IF/ID register with a one-entry skid buffer, redirect squash and halt handling.
module fetch #(
  parameter logic [15:0] ResetPc = 16'h0000,
  parameter logic [15:0] NopInst = 16'h1000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  imem_if.master      imem,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [15:0] redirect_pc_i,
  output logic [15:0] pc_o,
  output logic [15:0] pc_plus1_o,
  output logic [15:0] inst_o,
  output logic        inst_valid_o
);

  typedef enum logic [1:0] {StFetch, StHold, StHalted} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] next_q, next_d;
  logic        squash_q, squash_d;
  logic [15:0] skid_pc_q, skid_pc_d;
  logic [15:0] skid_inst_q, skid_inst_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] pc_plus1_q, pc_plus1_d;
  logic [15:0] inst_q, inst_d;
  logic        valid_q, valid_d;

  logic accept;
  logic rdata_halt;

  assign accept     = req_q & imem.ready & ~squash_q & ~redirect_i;
  assign rdata_halt = (imem.rdata[15:12] == 4'b0000);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    next_d      = next_q;
    squash_d    = squash_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    pc_d        = pc_q;
    pc_plus1_d  = pc_plus1_q;
    inst_d      = inst_q;
    valid_d     = valid_q;

    if (redirect_i) begin
      inst_d  = NopInst;
      valid_d = 1'b0;
      state_d = StFetch;
      // The outstanding request must complete before the address may change.
      if (req_q && !imem.ready) begin
        squash_d = 1'b1;
        next_d   = redirect_pc_i;
      end else begin
        squash_d = 1'b0;
        addr_d   = redirect_pc_i;
      end
    end else if (state_q == StHold) begin
      if (!stall_i) begin
        pc_d       = skid_pc_q;
        pc_plus1_d = skid_pc_q + 16'd1;
        inst_d     = skid_inst_q;
        valid_d    = 1'b1;
        state_d    = (skid_inst_q[15:12] == 4'b0000) ? StHalted : StFetch;
      end
    end else if (state_q == StFetch) begin
      if (req_q && imem.ready && squash_q) begin
        addr_d   = next_q;
        squash_d = 1'b0;
      end
      if (accept) begin
        addr_d = addr_q + 16'd1;
        if (stall_i) begin
          skid_pc_d   = addr_q;
          skid_inst_d = imem.rdata;
          state_d     = StHold;
        end else begin
          pc_d       = addr_q;
          pc_plus1_d = addr_q + 16'd1;
          inst_d     = imem.rdata;
          valid_d    = 1'b1;
          state_d    = rdata_halt ? StHalted : StFetch;
        end
      end else if (!stall_i) begin
        inst_d  = NopInst;
        valid_d = 1'b0;
      end
    end

    req_d = (state_d == StFetch);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StFetch;
      req_q       <= 1'b0;
      addr_q      <= ResetPc;
      next_q      <= ResetPc;
      squash_q    <= 1'b0;
      skid_pc_q   <= ResetPc;
      skid_inst_q <= NopInst;
      pc_q        <= ResetPc;
      pc_plus1_q  <= ResetPc + 16'd1;
      inst_q      <= NopInst;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      next_q      <= next_d;
      squash_q    <= squash_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      pc_q        <= pc_d;
      pc_plus1_q  <= pc_plus1_d;
      inst_q      <= inst_d;
      valid_q     <= valid_d;
    end
  end

  assign imem.req     = req_q;
  assign imem.addr    = addr_q;
  assign pc_o         = pc_q;
  assign pc_plus1_o   = pc_plus1_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: table-driven zero-wait/stall vectors plus hand sequences
// for wait states, squash, halt/redirect, async reset and a wrap-around reset PC.
module tb_fetch;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] pc, pc_plus1, inst;
  logic        inst_valid;
  logic [15:0] pc2, pc_plus1_2, inst2;
  logic        inst_valid2;

  int errors = 0;
  int checks = 0;
  int waits  = 0;
  int wcnt;
  logic [15:0] mem [256];

  imem_if u_if ();
  imem_if u_if2 ();

  fetch u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .imem         (u_if),
    .stall_i      (stall),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .pc_o         (pc),
    .pc_plus1_o   (pc_plus1),
    .inst_o       (inst),
    .inst_valid_o (inst_valid)
  );

  fetch #(.ResetPc(16'hFFFF), .NopInst(16'h1000)) u_dut2 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .imem         (u_if2),
    .stall_i      (1'b0),
    .redirect_i   (1'b0),
    .redirect_pc_i(16'h0000),
    .pc_o         (pc2),
    .pc_plus1_o   (pc_plus1_2),
    .inst_o       (inst2),
    .inst_valid_o (inst_valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model with a programmable number of wait cycles per request.
  assign u_if.ready = u_if.req && (wcnt == waits);
  assign u_if.rdata = u_if.ready ? mem[u_if.addr[7:0]] : 16'hDEAD;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt <= 0;
    else if (!u_if.req || u_if.ready) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  assign u_if2.ready = 1'b1;
  assign u_if2.rdata = {8'hB0, u_if2.addr[7:0]};

  typedef struct {
    logic        stall;
    logic [15:0] pc;
    logic [15:0] inst;
    logic        valid;
    logic        req;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    rst_n       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      stall = vecs[i].stall;
      step();
      chk($sformatf("row%0d pc", i), {16'h0, pc}, {16'h0, vecs[i].pc});
      chk($sformatf("row%0d pc+1", i), {16'h0, pc_plus1}, {16'h0, vecs[i].pc + 16'd1});
      chk($sformatf("row%0d inst", i), {16'h0, inst}, {16'h0, vecs[i].inst});
      chk($sformatf("row%0d valid", i), {31'h0, inst_valid}, {31'h0, vecs[i].valid});
      chk($sformatf("row%0d req", i), {31'h0, u_if.req}, {31'h0, vecs[i].req});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    for (int i = 0; i < 256; i++) mem[i] = 16'h2000 + 16'(i);
    mem[0] = 16'hC123; mem[1] = 16'hD456; mem[2] = 16'hE000; mem[3] = 16'h1000;
    mem[4] = 16'h0000; mem[5] = 16'h5555;
    mem[8'h10] = 16'hA111; mem[8'h11] = 16'hA222; mem[8'h40] = 16'h4444;

    // {stall, pc, inst, valid, req} after each edge
    vecs[0]  = '{1'b0, 16'h0000, 16'h1000, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 16'h0000, 16'hC123, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 16'h0001, 16'hD456, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 16'h0002, 16'hE000, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 16'h0003, 16'h1000, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 16'h0004, 16'h0000, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 16'h0004, 16'h0000, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 16'h0000, 16'h1000, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 16'h0000, 16'h1000, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 16'h0000, 16'h1000, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 16'h0000, 16'h1000, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 16'h0000, 16'hC123, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 16'h0001, 16'hD456, 1'b1, 1'b1};

    // Reset values, and the 16'hFFFF reset-PC instance wrapping to 0.
    do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst pc", {16'h0, pc}, 32'h0000);
    chk("rst pc+1", {16'h0, pc_plus1}, 32'h0001);
    chk("rst inst", {16'h0, inst}, 32'h1000);
    chk("rst valid", {31'h0, inst_valid}, 32'h0);
    chk("rst req", {31'h0, u_if.req}, 32'h0);
    chk("rst addr", {16'h0, u_if.addr}, 32'h0000);
    chk("wrap rst pc", {16'h0, pc2}, 32'hFFFF);
    chk("wrap rst pc+1", {16'h0, pc_plus1_2}, 32'h0000);
    do_reset();
    step();
    chk("wrap edge1 valid", {31'h0, inst_valid2}, 32'h0);
    step();
    chk("wrap edge2 pc", {16'h0, pc2}, 32'hFFFF);
    chk("wrap edge2 pc+1", {16'h0, pc_plus1_2}, 32'h0000);
    chk("wrap edge2 inst", {16'h0, inst2}, 32'hB0FF);
    step();
    chk("wrap edge3 pc", {16'h0, pc2}, 32'h0000);
    chk("wrap edge3 inst", {16'h0, inst2}, 32'hB000);

    // Zero-wait stream up to halt, then redirect out of HALTED.
    waits = 0;
    do_reset();
    run_rows(0, 6);
    redirect = 1'b1; redirect_pc = 16'h0010;
    step();
    redirect = 1'b0;
    chk("halt redir valid", {31'h0, inst_valid}, 32'h0);
    chk("halt redir pc", {16'h0, pc}, 32'h0004);
    chk("halt redir req", {31'h0, u_if.req}, 32'h1);
    chk("halt redir addr", {16'h0, u_if.addr}, 32'h0010);
    step();
    chk("restart inst0", {16'h0, inst}, 32'hA111);
    chk("restart pc0", {16'h0, pc}, 32'h0010);
    step();
    chk("restart inst1", {16'h0, inst}, 32'hA222);
    chk("restart pc1", {16'h0, pc}, 32'h0011);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async rst req", {31'h0, u_if.req}, 32'h0);
    chk("async rst pc", {16'h0, pc}, 32'h0000);
    chk("async rst pc+1", {16'h0, pc_plus1}, 32'h0001);
    chk("async rst inst", {16'h0, inst}, 32'h1000);
    chk("async rst valid", {31'h0, inst_valid}, 32'h0);

    // Stall while the first instruction returns: skid/HOLD.
    do_reset();
    run_rows(7, 12);

    // Two wait cycles: stable address, two bubbles per instruction.
    waits = 2;
    do_reset();
    step();
    chk("w2 e1 req", {31'h0, u_if.req}, 32'h1);
    for (int e = 2; e <= 3; e++) begin
      step();
      chk($sformatf("w2 e%0d addr", e), {16'h0, u_if.addr}, 32'h0000);
      chk($sformatf("w2 e%0d valid", e), {31'h0, inst_valid}, 32'h0);
      chk($sformatf("w2 e%0d inst", e), {16'h0, inst}, 32'h1000);
    end
    step();
    chk("w2 e4 inst", {16'h0, inst}, 32'hC123);
    chk("w2 e4 valid", {31'h0, inst_valid}, 32'h1);
    for (int e = 5; e <= 6; e++) begin
      step();
      chk($sformatf("w2 e%0d addr", e), {16'h0, u_if.addr}, 32'h0001);
      chk($sformatf("w2 e%0d valid", e), {31'h0, inst_valid}, 32'h0);
      chk($sformatf("w2 e%0d pc", e), {16'h0, pc}, 32'h0000);
    end
    step();
    chk("w2 e7 inst", {16'h0, inst}, 32'hD456);
    chk("w2 e7 pc", {16'h0, pc}, 32'h0001);

    // Redirect during an outstanding 3-wait fetch of 0x0005 squashes it.
    waits = 3;
    do_reset();
    redirect = 1'b1; redirect_pc = 16'h0005;
    step();
    redirect = 1'b0;
    chk("sq addr5", {16'h0, u_if.addr}, 32'h0005);
    step();
    redirect = 1'b1; redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    chk("sq held addr", {16'h0, u_if.addr}, 32'h0005);
    chk("sq valid", {31'h0, inst_valid}, 32'h0);
    step();
    chk("sq req", {31'h0, u_if.req}, 32'h1);
    step();
    chk("sq new addr", {16'h0, u_if.addr}, 32'h0040);
    chk("sq discarded", {31'h0, inst_valid}, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = inst_valid;
    end
    chk("sq got valid", {31'h0, found}, 32'h1);
    chk("sq first pc", {16'h0, pc}, 32'h0040);
    chk("sq first inst", {16'h0, inst}, 32'h4444);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
